// File: rtl/cdu_pulse_scheduler.sv
// Round-robin scheduler that time-shares one AGC counter-increment port among the CDU channels.
// Each channel accumulates signed +/- pulses; at most one pulse is granted per scheduling slot.
module cdu_pulse_scheduler #(
    parameter int NCH      = 5,
    parameter int TICK_DIV = 64,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] up_req,
    input  logic [NCH-1:0] dn_req,
    input  logic [NCH-1:0] ch_zero,
    output logic           cnt_valid,
    output logic [2:0]     cnt_sel,
    output logic           cnt_up,
    output logic           cnt_dn,
    input  logic           cnt_ack,
    output logic [NCH-1:0] ovf,
    output logic           busy
);

    localparam int SLOT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PMAX   = (1 << (CNT_W - 1)) - 1;

    typedef enum logic [1:0] {IDLE, SCAN, OFFER, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [SLOT_W-1:0]       slot_q;
    logic                    slot_tick;
    logic [2:0]              rr_q, sel_q;
    logic                    dir_up_q;
    logic signed [CNT_W-1:0] pend_q [NCH];
    logic signed [CNT_W-1:0] pend_d [NCH];
    logic [NCH-1:0]          ovf_d;
    logic                    found;
    logic [2:0]              found_idx;
    logic [3:0]              cand;
    logic                    abort, ack_fire;
    int                      sum;

    always_ff @(posedge clk) begin
        if (rst || slot_tick) slot_q <= '0;
        else                  slot_q <= slot_q + 1'b1;
    end
    assign slot_tick = (slot_q == SLOT_W'(TICK_DIV - 1));

    // Handshake: an offer (cnt_valid with cnt_sel/cnt_up/cnt_dn stable) is consumed on the
    // first edge where cnt_ack is high; cnt_ack while cnt_valid is low has no effect.
    assign abort    = (state_q == OFFER) && ch_zero[sel_q];
    assign ack_fire = (state_q == OFFER) && cnt_ack && !abort;

    // First eligible channel starting at the round-robin pointer.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        cand      = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, rr_q} + 4'(i);
            if (cand >= 4'(NCH)) cand = cand - 4'(NCH);
            if (!found && pend_q[cand[2:0]] != '0 && !ch_zero[cand[2:0]]) begin
                found     = 1'b1;
                found_idx = cand[2:0];
            end
        end
    end

    always_comb begin
        sum = 0;
        for (int c = 0; c < NCH; c++) begin
            sum = int'(pend_q[c]) + int'(up_req[c]) - int'(dn_req[c]);
            if (ack_fire && sel_q == 3'(c)) sum = dir_up_q ? sum - 1 : sum + 1;
            pend_d[c] = CNT_W'(sum);
            ovf_d[c]  = ovf[c];
            if (sum > PMAX) begin
                pend_d[c] = CNT_W'(PMAX);
                ovf_d[c]  = 1'b1;
            end else if (sum < -PMAX) begin
                pend_d[c] = CNT_W'(-PMAX);
                ovf_d[c]  = 1'b1;
            end
            if (ch_zero[c]) begin
                pend_d[c] = '0;
                ovf_d[c]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) pend_q[c] <= '0;
            ovf <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) pend_q[c] <= pend_d[c];
            ovf <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (slot_tick) state_d = SCAN;
            SCAN:    state_d = found ? OFFER : IDLE;
            OFFER: begin
                if (abort)        state_d = IDLE;
                else if (cnt_ack) state_d = HOLD;
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_valid = (state_q == OFFER);
        cnt_up    = cnt_valid && dir_up_q;
        cnt_dn    = cnt_valid && !dir_up_q;
        cnt_sel   = sel_q;
    end

    // Grant is frozen at SCAN; the pointer only moves past a channel that was actually served.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= '0;
            dir_up_q <= 1'b0;
            rr_q     <= '0;
        end else begin
            if (state_q == SCAN && found) begin
                sel_q    <= found_idx;
                dir_up_q <= !pend_q[found_idx][CNT_W-1];
            end
            if (ack_fire) rr_q <= (sel_q == 3'(NCH - 1)) ? 3'd0 : sel_q + 3'd1;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int c = 0; c < NCH; c++) if (pend_q[c] != '0) busy = 1'b1;
    end

endmodule
